fir_filter_param: RTL

Parametrised, time-multiplexed FIR filter: a generalised successor of the fixed 8-bit filter. Each accepted sample is shifted into a TAPS-deep delay line, and one multiply-accumulate is performed per clock. The result is rounded, scaled and saturated to OUT_W bits. Coefficients are runtime-loadable through a write port. The block sits between the sample source and the downstream sink, with a valid/ready handshake on the input and a one-cycle valid pulse on the output.

---
 rtl/fir_filter_param_if.sv | 36 +++
 rtl/fir_filter_param.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fir_filter_param_if.sv
// rtl/fir_filter_param_if.sv - sample, coefficient and result signals of fir_filter_param
interface fir_filter_param_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 8
);
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  // sample input handshake
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  // coefficient write port
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;

  // filtered result, one-cycle pulse
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;

  // sample source / coefficient host / result sink side
  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, out_sat
  );

  // filter side
  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fir_filter_param.sv
// rtl/fir_filter_param.sv - time-multiplexed FIR, one MAC per clock, rounded and saturated output
module fir_filter_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 16,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  fir_filter_param_if.slave bus
);
  localparam int AW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  // clog2(TAPS) guard bits keep the sum of TAPS full-precision products exact
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  // wide enough to add the rounding constant and compare against the output range
  localparam int RW     = ACC_W + OUT_W + 1;

  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
  localparam logic signed [RW-1:0] SAT_MAX =
    {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN =
    {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q [TAPS];
  logic signed [COEF_W-1:0]  c_q [TAPS];
  logic signed [ACC_W-1:0]   acc_q;
  logic [AW-1:0]             k_q;
  logic [OUT_W-1:0]          out_data_q, out_data_d;
  logic                      out_valid_q;
  logic                      out_sat_q, out_sat_d;

  logic                      accept;
  logic                      coef_wr;
  logic                      last_tap;
  logic signed [PROD_W-1:0]  prod;
  logic signed [RW-1:0]      acc_ext;
  logic signed [RW-1:0]      rounded;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  // out-of-range tap indices (possible when TAPS is not a power of two) are dropped
  assign coef_wr  = (state_q == IDLE) && bus.coef_we && (32'(bus.coef_addr) < TAPS);
  assign last_tap = (k_q == AW'(TAPS - 1));
  assign prod     = PROD_W'(x_q[k_q]) * PROD_W'(c_q[k_q]);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: one accepted sample walks IDLE -> MAC (TAPS cycles) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = MAC;
      MAC:     if (last_tap)     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // delay line, coefficient store and multiply-accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      acc_q <= '0;
      k_q   <= '0;
    end else begin
      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) begin
          x_q[i] <= x_q[i-1];
        end
        x_q[0] <= bus.in_data;
        acc_q  <= '0;
        k_q    <= '0;
      end
      // a write in the acceptance cycle lands before the MAC reads it, so it applies to that sample
      if (coef_wr) begin
        c_q[bus.coef_addr] <= bus.coef_data;
      end
      if (state_q == MAC) begin
        acc_q <= acc_q + ACC_W'(prod);
        k_q   <= k_q + AW'(1);
      end
    end
  end

  // round half up, arithmetic shift, then clip to the signed output range
  always_comb begin
    acc_ext    = RW'(acc_q);
    rounded    = (acc_ext + RND) >>> SHIFT;
    out_data_d = rounded[OUT_W-1:0];
    out_sat_d  = 1'b0;
    if (rounded > SAT_MAX) begin
      out_data_d = SAT_MAX[OUT_W-1:0];
      out_sat_d  = 1'b1;
    end else if (rounded < SAT_MIN) begin
      out_data_d = SAT_MIN[OUT_W-1:0];
      out_sat_d  = 1'b1;
    end
  end

  // result register: data holds between pulses, valid/sat are single-cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= (state_q == DONE);
      out_sat_q   <= (state_q == DONE) && out_sat_d;
      if (state_q == DONE) begin
        out_data_q <= out_data_d;
      end
    end
  end
endmodule
